// File: rtl/writeback_block.sv
// Eviction writeback engine: 2-entry request FIFO feeding a byte-serial
// memory write FSM (IDLE -> WRITE x block_size_byte -> DONE).
module writeback_block #(
  parameter int way             = 16,
  parameter int block_size_byte = 4,
  parameter int cache_size_byte = 65536,
  localparam int BO = $clog2(block_size_byte),
  localparam int SI = $clog2(cache_size_byte / (block_size_byte * way)),
  localparam int TW = 16 - SI - BO,
  localparam int BW = block_size_byte * 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [TW-1:0] tag,
  input  logic [SI-1:0] index,
  input  logic [BW-1:0] block,
  output logic          mem_en,
  output logic          mem_we,
  output logic [15:0]   mem_addr,
  output logic [7:0]    mem_din,
  output logic          wb_busy,
  output logic          wb_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [BO-1:0] LAST = BO'(block_size_byte - 1);

  // FIFO storage and control
  logic [TW-1:0] r_ftag [2];
  logic [SI-1:0] r_fidx [2];
  logic [BW-1:0] r_fblk [2];
  logic          r_wptr;
  logic          r_rptr;
  logic [1:0]    r_count;

  // Working registers for the block being written
  logic [1:0]    r_state;
  logic [BO-1:0] r_cnt;
  logic [TW-1:0] r_tag;
  logic [SI-1:0] r_idx;
  logic [BW-1:0] r_blk;

  logic          r_mem_en;
  logic          r_mem_we;
  logic [15:0]   r_mem_addr;
  logic [7:0]    r_mem_din;
  logic          r_wb_done;

  logic          w_push;
  logic          w_pop;
  logic [BO-1:0] w_cnt_nxt;

  assign req_ready = !reset && (r_count < 2'd2);
  assign w_push    = req_valid && req_ready;
  assign w_pop     = (r_state == S_IDLE) && (r_count != 2'd0);
  assign w_cnt_nxt = r_cnt + 1'b1;

  assign mem_en   = r_mem_en;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;
  assign wb_done  = r_wb_done;
  assign wb_busy  = (r_count != 2'd0) || (r_state != S_IDLE);

  // FIFO payload capture; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ftag[r_wptr] <= tag;
      r_fidx[r_wptr] <= index;
      r_fblk[r_wptr] <= block;
    end
  end

  // FIFO pointers and occupancy; push+pop together keeps count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      if (w_push && !w_pop)
        r_count <= r_count + 2'd1;
      else if (!w_push && w_pop)
        r_count <= r_count - 2'd1;
    end
  end

  // Writeback FSM with registered memory-port outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_tag      <= '0;
      r_idx      <= '0;
      r_blk      <= '0;
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_wb_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wb_done <= 1'b0;
          if (w_pop) begin
            r_tag      <= r_ftag[r_rptr];
            r_idx      <= r_fidx[r_rptr];
            r_blk      <= r_fblk[r_rptr];
            r_cnt      <= '0;
            r_mem_en   <= 1'b1;
            r_mem_we   <= 1'b1;
            r_mem_addr <= {r_ftag[r_rptr], r_fidx[r_rptr], {BO{1'b0}}};
            r_mem_din  <= r_fblk[r_rptr][7:0];
            r_state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (r_cnt == LAST) begin
            r_mem_en  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_wb_done <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt      <= w_cnt_nxt;
            r_mem_addr <= {r_tag, r_idx, w_cnt_nxt};
            r_mem_din  <= r_blk[{w_cnt_nxt, 3'b000} +: 8];
          end
        end
        S_DONE: begin
          r_wb_done <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_mem_en  <= 1'b0;
          r_mem_we  <= 1'b0;
          r_wb_done <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_block.sv
// Bench for writeback_block: timing-level reference model of the queue
// and block service schedule, plus directed scenarios.
module tb_writeback_block;

  localparam int BS = 4;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  tag;
  logic [9:0]  index;
  logic [31:0] block;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        wb_busy;
  logic        wb_done;

  writeback_block dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .tag       (tag),
    .index     (index),
    .block     (block),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .wb_busy   (wb_busy),
    .wb_done   (wb_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  t;
    logic [9:0]  ix;
    logic [31:0] b;
  } req_t;

  int checks = 0;
  int errors = 0;

  req_t        mq[$];
  req_t        cur;
  bit          have_cur = 0;
  int          start = 0;
  int          next_free = 0;
  int          cyc = 0;
  bit          acc;
  logic [15:0] last_addr = '0;
  logic [7:0]  last_din = '0;
  logic [23:0] wlog[$];
  int          done_cyc[$];

  logic [23:0] exp_single [4] = '{24'hA554AA, 24'hA555BB,
                                  24'hA556CC, 24'hA557DD};
  logic [23:0] exp_ab [8] = '{24'h301444, 24'h301533,
                              24'h301622, 24'h301711,
                              24'hCAA888, 24'hCAA977,
                              24'hCAAA66, 24'hCAAB55};

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // One clock: drive inputs, check ready, advance model, check outputs.
  task automatic step(input bit v, input logic [3:0] t,
                      input logic [9:0] ix, input logic [31:0] b,
                      input bit r);
    bit   er;
    bit   e_en;
    bit   e_done;
    bit   e_busy;
    int   k;
    req_t n;
    reset     = r;
    req_valid = v;
    tag       = t;
    index     = ix;
    block     = b;
    #1;
    er = !r && (mq.size() < 2);
    chk("req_ready", {31'd0, req_ready}, {31'd0, er});
    @(posedge clk);
    cyc++;
    acc = 0;
    if (r) begin
      mq.delete();
      have_cur  = 0;
      next_free = 0;
      last_addr = '0;
      last_din  = '0;
    end else begin
      if (cyc >= next_free && mq.size() > 0) begin
        cur       = mq.pop_front();
        have_cur  = 1;
        start     = cyc;
        next_free = cyc + BS + 2;
      end
      if (v && er) begin
        n.t  = t;
        n.ix = ix;
        n.b  = b;
        mq.push_back(n);
        acc = 1;
      end
    end
    k = cyc - start;
    e_en = 0;
    if (!r && have_cur && k < BS) begin
      e_en      = 1;
      last_addr = {cur.t, cur.ix, k[1:0]};
      last_din  = cur.b[8*k +: 8];
    end
    e_done = !r && have_cur && (k == BS);
    e_busy = !r && (mq.size() > 0 || (have_cur && k <= BS));
    #1;
    chk("mem_en",   {31'd0, mem_en},  {31'd0, e_en});
    chk("mem_we",   {31'd0, mem_we},  {31'd0, e_en});
    chk("wb_done",  {31'd0, wb_done}, {31'd0, e_done});
    chk("wb_busy",  {31'd0, wb_busy}, {31'd0, e_busy});
    chk("mem_addr", {16'd0, mem_addr}, {16'd0, last_addr});
    chk("mem_din",  {24'd0, mem_din},  {24'd0, last_din});
    if (mem_en) wlog.push_back({mem_addr, mem_din});
    if (wb_done) done_cyc.push_back(cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'h0, 10'h0, 32'h0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int push_cyc;
    int tries;
    // reset state
    step(1, 4'hF, 10'h3FF, 32'hFFFF_FFFF, 1);
    step(0, 4'h0, 10'h0, 32'h0, 1);

    // single request, exact addresses and data
    wlog.delete();
    done_cyc.delete();
    step(1, 4'hA, 10'h155, 32'hDDCCBBAA, 0);
    push_cyc = cyc;
    idle(8);
    chk("single_nwrites", wlog.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("single_write", {8'd0, wlog[i]}, {8'd0, exp_single[i]});
    chk("single_ndone", done_cyc.size(), 1);
    chk("single_done_lat", done_cyc[0], push_cyc + BS + 1);

    // three back-to-back requests held valid
    done_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      tries = 0;
      do begin
        step(1, 4'(i + 1), 10'(i * 7 + 1), $urandom, 0);
        tries++;
      end while (!acc && tries < 20);
      chk("b2b_accept", {31'd0, acc}, 32'd1);
    end
    idle(25);
    chk("b2b_ndone", done_cyc.size(), 3);
    chk("b2b_gap1", done_cyc[1] - done_cyc[0], BS + 2);
    chk("b2b_gap2", done_cyc[2] - done_cyc[1], BS + 2);

    // reset after second byte of a block
    wlog.delete();
    done_cyc.delete();
    step(1, 4'h6, 10'h0F0, 32'h87654321, 0);
    idle(2);
    chk("rst_mid_bytes", wlog.size(), 2);
    step(1, 4'h7, 10'h111, 32'h0BADF00D, 1);
    chk("rst_mid_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mid_busy", {31'd0, wb_busy}, 32'd0);
    wlog.delete();
    idle(10);
    chk("rst_mid_nodone", done_cyc.size(), 0);
    chk("rst_mid_nowrite", wlog.size(), 0);

    // push B while A is being written
    wlog.delete();
    step(1, 4'h3, 10'h005, 32'h11223344, 0);
    step(0, 4'h0, 10'h0, 32'h0, 0);
    step(1, 4'hC, 10'h2AA, 32'h55667788, 0);
    idle(15);
    chk("ab_nwrites", wlog.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("ab_write", {8'd0, wlog[i]}, {8'd0, exp_ab[i]});

    // long idle
    done_cyc.delete();
    wlog.delete();
    idle(100);
    chk("idle_nodone", done_cyc.size(), 0);
    chk("idle_nowrite", wlog.size(), 0);

    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 1)), 4'($urandom),
           10'($urandom), $urandom,
           $urandom_range(0, 79) == 0);
    end
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
